// File: rtl/regwb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (port 0) versus a buffered
// multi-cycle result (port 1), with a starvation limit that forces port 1 through.
module regwb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int DW           = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic [4:0]    addr0,
   input  logic [DW-1:0] data0,
   output logic          stall0,
   input  logic          req1,
   input  logic [4:0]    addr1,
   input  logic [DW-1:0] data1,
   output logic          rdy1,
   output logic          sel,
   output logic          we,
   output logic [4:0]    wa,
   output logic [DW-1:0] wd,
   output logic          pend1
);

   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic [4:0]      buf_addr_reg;
   logic [DW-1:0]   buf_data_reg;
   logic            rdy1_reg;
   logic            we_reg, sel_reg;
   logic [4:0]      wa_reg;
   logic [DW-1:0]   wd_reg;
   logic            grant0, grant1, accept;

   assign accept = req1 & rdy1_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      grant0     = 1'b0;
      grant1     = 1'b0;
      stall0     = 1'b0;
      case (state_reg)
         IDLE: begin
            grant0 = req0;
         end
         WAIT: begin
            if (req0) begin
               grant0   = 1'b1;
               cnt_next = cnt_reg + 4'd1;
               if (cnt_reg + 4'd1 >= LIMIT_C) state_next = FORCE;
            end else begin
               grant1 = 1'b1;
            end
         end
         FORCE: begin
            grant1 = 1'b1;
            stall0 = req0;
         end
         default: state_next = IDLE;
      endcase
      if (grant1) begin
         state_next = IDLE;
         cnt_next   = 4'd0;
      end
      // A fresh capture always restarts the starvation window.
      if (accept) begin
         state_next = WAIT;
         cnt_next   = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= 4'd0;
         rdy1_reg     <= 1'b1;
         buf_addr_reg <= 5'd0;
         buf_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdy1_reg  <= (state_next == IDLE);
         if (accept) begin
            buf_addr_reg <= addr1;
            buf_data_reg <= data1;
         end
      end
   end

   // Writes to $0 are consumed but never enabled on the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg  <= 1'b0;
         sel_reg <= 1'b0;
         wa_reg  <= 5'd0;
         wd_reg  <= '0;
      end else if (grant1) begin
         we_reg  <= (buf_addr_reg != 5'd0);
         sel_reg <= 1'b1;
         wa_reg  <= buf_addr_reg;
         wd_reg  <= buf_data_reg;
      end else if (grant0) begin
         we_reg  <= (addr0 != 5'd0);
         sel_reg <= 1'b0;
         wa_reg  <= addr0;
         wd_reg  <= data0;
      end else begin
         we_reg  <= 1'b0;
      end
   end

   assign rdy1  = rdy1_reg;
   assign pend1 = (state_reg != IDLE);
   assign we    = we_reg;
   assign sel   = sel_reg;
   assign wa    = wa_reg;
   assign wd    = wd_reg;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboard bench for regwb_arbiter: a cycle model predicts each write-port update
// when stimulus is applied; the prediction is popped and compared after the edge.
module tb_regwb_arbiter;
   localparam int LIM = 4;
   localparam int DW  = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1;
   logic [4:0]    addr0, addr1;
   logic [DW-1:0] data0, data1;
   logic          stall0, rdy1, sel, we, pend1;
   logic [4:0]    wa;
   logic [DW-1:0] wd;

   regwb_arbiter #(.STARVE_LIMIT(LIM), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .data0(data0), .stall0(stall0),
      .req1(req1), .addr1(addr1), .data1(data1), .rdy1(rdy1),
      .sel(sel), .we(we), .wa(wa), .wd(wd), .pend1(pend1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          we;
      logic          sel;
      logic [4:0]    wa;
      logic [DW-1:0] wd;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   // model state
   logic          m_pend;
   int            m_cnt;
   logic [4:0]    m_baddr;
   logic [DW-1:0] m_bdata;
   wr_t           m_out;
   int            p1_writes;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_pend  = 1'b0;
      m_cnt   = 0;
      m_baddr = 5'd0;
      m_bdata = '0;
      m_out   = '0;
   endtask

   task automatic cyc(input logic r0, input logic [4:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic [4:0] a1, input logic [DW-1:0] d1);
      logic g0, g1, acc;
      wr_t  nxt, got;
      @(negedge clk);
      req0 = r0; addr0 = a0; data0 = d0;
      req1 = r1; addr1 = a1; data1 = d1;
      #1;
      g1  = m_pend && ((m_cnt == LIM) || !r0);
      g0  = r0 && !g1;
      acc = r1 && !m_pend;
      chk("stall0", 64'(stall0), 64'(m_pend && (m_cnt == LIM) && r0));
      chk("rdy1",   64'(rdy1),   64'(!m_pend));
      chk("pend1",  64'(pend1),  64'(m_pend));
      nxt = m_out;
      nxt.we = 1'b0;
      if (g1) begin
         nxt = '{we: (m_baddr != 0), sel: 1'b1, wa: m_baddr, wd: m_bdata};
         p1_writes++;
      end else if (g0) begin
         nxt = '{we: (a0 != 0), sel: 1'b0, wa: a0, wd: d0};
      end
      exp_q.push_back(nxt);
      if (g1) begin
         m_pend = 1'b0;
         m_cnt  = 0;
      end else if (m_pend && g0) begin
         m_cnt++;
      end
      if (acc) begin
         m_pend  = 1'b1;
         m_cnt   = 0;
         m_baddr = a1;
         m_bdata = d1;
      end
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
         got = exp_q.pop_front();
         chk("we",  64'(we),  64'(got.we));
         chk("sel", 64'(sel), 64'(got.sel));
         chk("wa",  64'(wa),  64'(got.wa));
         chk("wd",  64'(wd),  64'(got.wd));
         m_out = got;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
   endtask

   initial begin
      p1_writes = 0;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",    64'(we),    64'd0);
      chk("rst_sel",   64'(sel),   64'd0);
      chk("rst_wa",    64'(wa),    64'd0);
      chk("rst_wd",    64'(wd),    64'd0);
      chk("rst_pend1", 64'(pend1), 64'd0);
      chk("rst_rdy1",  64'(rdy1),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single port-0 write
      cyc(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, '0);
      chk("t1_wd", 64'(wd), 64'h1234);
      idle(1);
      chk("t1_we_low", 64'(we), 64'd0);

      // 2: port-1 write through an idle port 0
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'hDEAD_BEEF);
      idle(1);
      chk("t2_wd",  64'(wd),  64'hDEAD_BEEF);
      chk("t2_sel", 64'(sel), 64'd1);
      idle(1);

      // 3: starvation limit forces port 1 through a busy port 0
      cyc(1'b1, 5'd7, 32'hA000_0000, 1'b1, 5'd3, 32'h0000_0333);
      for (int i = 1; i <= 6; i++) cyc(1'b1, 5'd7, 32'hA000_0000 + 32'(i), 1'b0, 5'd0, '0);
      idle(2);

      // 4: writes to $0 are consumed without a write enable
      cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, '0);
      cyc(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h0000_0055);
      idle(1);
      chk("t4_we0", 64'(we), 64'd0);
      chk("t4_rdy1", 64'(rdy1), 64'd1);

      // 5: second req1 held while the buffer is occupied
      cyc(1'b1, 5'd4, 32'h4444, 1'b1, 5'd10, 32'h1010);
      for (int i = 0; i < 8; i++) cyc(1'b1, 5'd4, 32'h4400 + 32'(i), 1'b1, 5'd11, 32'h1111);
      idle(3);

      // random mix
      for (int i = 0; i < 60; i++)
         cyc(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      idle(3);

      // 6: asynchronous reset while in FORCE with a write in flight
      p1_writes = 0;
      cyc(1'b1, 5'd7, 32'h7777, 1'b1, 5'd3, 32'h3333);
      for (int i = 0; i < LIM; i++) cyc(1'b1, 5'd7, 32'h7700 + 32'(i), 1'b0, 5'd0, '0);
      chk("t6_pre_we",   64'(we),    64'd1);
      chk("t6_pre_pend", 64'(pend1), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_we",    64'(we),    64'd0);
      chk("t6_pend1", 64'(pend1), 64'd0);
      chk("t6_sel",   64'(sel),   64'd0);
      chk("t6_rdy1",  64'(rdy1),  64'd1);
      model_reset();
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req0 = 0; req1 = 0;
      idle(4);
      chk("t6_no_stale", 64'(p1_writes), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regwb_arbiter.md
Name: regwb_arbiter

Overview:
- Shares the single register-file write port of the MIPS core between two requesters: port 0 is the pipeline writeback (ALU/load) and port 1 is a multi-cycle unit (mult/div result return).
- Drives the 5-bit write-address select between the two sources.
- Registers the winning address/data onto the register-file write port.
- Holds port 1 results in a one-entry buffer so the multi-cycle unit can retire without stalling.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a buffered port-1 result may lose to port 0 before it is forced through (range 1..15).
- DW, 32, write-data width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port-0 write request (pipeline writeback)
- addr0  in  5  port-0 destination register
- data0  in  DW  port-0 write data
- stall0  out  1  port-0 must hold req0/addr0/data0 this cycle (combinational)
- req1  in  1  port-1 write request (multi-cycle unit)
- addr1  in  5  port-1 destination register
- data1  in  DW  port-1 write data
- rdy1  out  1  port-1 buffer empty; a req1 is accepted this cycle (registered)
- sel  out  1  write-address select: 0 = port 0, 1 = port 1 (registered)
- we  out  1  register-file write enable (registered)
- wa  out  5  register-file write address (registered)
- wd  out  DW  register-file write data (registered)
- pend1  out  1  port-1 buffer occupied (registered)

Behaviour:
- Reset (rst_n low, asynchronous):
  - we=0, sel=0, wa=0, wd=0.
  - pend1=0, rdy1=1, starvation counter=0.
  - State forced to IDLE; a buffered port-1 entry is discarded.
- Port-1 buffer:
  - req1 and rdy1 high at a rising edge: addr1/data1 are captured and pend1 goes high next cycle. rdy1 = !pend1, registered.
  - req1 while rdy1=0 is ignored; the requester holds req1.
- States:
  - IDLE: pend1=0.
  - WAIT: pend1=1, counter < STARVE_LIMIT.
  - FORCE: pend1=1, counter = STARVE_LIMIT.
- Grant per cycle:
  - IDLE: req0 → grant 0.
  - WAIT: req0 → grant 0 and counter+1; otherwise grant 1.
  - FORCE: grant 1 unconditionally and stall0=1 if req0.
- Any grant 1:
  - Clears pend1 and resets the counter.
  - Returns to IDLE.
  - rdy1 high the following cycle.
- Grant 0 with req0 high latches, next edge: sel=0, wa=addr0, wd=data0, we=1.
- Grant 1 latches, next edge: sel=1, wa=buffered addr, wd=buffered data, we=1.
- No grant: we=0; sel, wa and wd hold their previous values.
- Latency: one cycle from grant to we/wa/wd valid. stall0 is the only combinational output; stall0 = FORCE & req0.
- Register $0:
  - A grant whose address is 0 is consumed normally: buffer freed, counter reset, or port 0 not stalled.
  - In that case we stays 0 next cycle. wa/wd/sel still update.
- Same-cycle req1 accept and buffered grant 1 (FORCE or no req0): the buffer frees and refills on the same edge. pend1 stays 1, the counter restarts at 0 and the state is WAIT.
  - rdy1 was 0 that cycle, so this case can occur only if rdy1 had been 1. It therefore applies only when pend1 was 0, i.e. it cannot occur. The bench must confirm accept never happens while pend1=1.
- Ordering: port 0 and the buffered entry may target the same register. The grant that completes later defines the final register value. No write merging or reordering is performed.
- Counter: 4 bits, saturates at STARVE_LIMIT, never wraps.
- Reset mid-operation clears an in-flight we the same instant; no partial write is issued after reset release.

Test Plan:
1. Reset, then req0 with addr0=5, data0=0x0000_1234 for 1 cycle → next cycle we=1, sel=0, wa=5, wd=0x1234; the cycle after, we=0.
2. Idle port 0, req1 with addr1=9, data1=0xDEAD_BEEF → pend1=1 next cycle, then we=1, sel=1, wa=9, wd=0xDEADBEEF; rdy1 back to 1.
3. req1 accepted (addr1=3), req0 held high continuously with addr0=7, STARVE_LIMIT=4 → four port-0 writes to 7, stall0=1 in the fifth cycle, port-1 write to 3 follows, then port-0 resumes.
4. req0 with addr0=0, data0=0xFFFF_FFFF → we stays 0, stall0=0, no register write; req1 with addr1=0 frees the buffer (rdy1=1) with we=0.
5. Second req1 while pend1=1 and port 0 busy → rdy1=0, request ignored until the first entry is written; the second capture occurs one cycle after rdy1 rises.
6. Assert rst_n=0 in FORCE with pend1=1 and we=1 → we, pend1 and sel go to 0 immediately; after release, no stale port-1 write appears.
